// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
//   fetch_state_e     : fetch FSM states (request / wait for data / hold word for decode)
//   RESET_PC_DEFAULT  : default PC after reset
//   NOP_INST          : word presented in place of a misaligned fetch (addi x0,x0,0)
//   PC_STEP           : sequential PC increment in bytes
package inst_fetch_pkg;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam int          PC_STEP          = 4;

endpackage

// File: rtl/inst_fetch_pc.sv
// Program counter register with its next-PC selection.
// Priority: reset > redirect > sequential advance (pc + 4, wraps modulo 2^ADDR_W) > hold.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   redir_valid  : load redir_pc
//   redir_pc     : redirect target
//   advance      : step to the next sequential instruction
//   pc           : current PC
module inst_fetch_pc
  import inst_fetch_pkg::*;
#(
  parameter int              ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redir_valid,
  input  logic [ADDR_W-1:0] redir_pc,
  input  logic              advance,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (redir_valid) begin
      pc_d = redir_pc;
    end else if (advance) begin
      pc_d = pc_q + ADDR_W'(PC_STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: holds the PC, issues one doubleword read at a time and
// hands the selected 32-bit word plus its address to decode over valid/ready.
// Redirects from execute replace the PC in any state; a response that belongs to
// a superseded PC is dropped.
// Optional build macro INST_FETCH_ALIGN_CHK_EN: a PC with pc[1:0] != 0 issues no
// read and presents a nop with inst_excp set instead.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   mem_req/mem_gnt/mem_addr : read request, held until granted, 8-byte aligned
//   mem_rvalid/mem_rdata     : read response, one per granted request
//   inst_valid/inst_ready    : handshake to decode
//   inst/inst_pc/inst_excp   : instruction word, its address, misaligned flag
//   redir_valid/redir_pc     : PC redirect from execute
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_REQ  | request pending for the current PC (held until granted)
// ST_WAIT | request granted, waiting for read data (may be marked discard)
// ST_HOLD | word presented to decode, waiting for handshake or redirect
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [63:0]       mem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_excp,
  input  logic              redir_valid,
  input  logic [ADDR_W-1:0] redir_pc
);

`ifdef INST_FETCH_ALIGN_CHK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  fetch_state_e      state_q, state_d;
  logic              discard_q, discard_d;
  logic [31:0]       inst_q, inst_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic              excp_q, excp_d;

  logic [ADDR_W-1:0] pc;
  logic              advance;
  logic              req_int;
  logic              misaligned;
  logic [31:0]       word_sel;

  inst_fetch_pc #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk         (clk),
    .rst         (rst),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .advance     (advance),
    .pc          (pc)
  );

  assign misaligned = ALIGN_CHK && (pc[1:0] != 2'b00);
  assign word_sel   = pc[2] ? mem_rdata[63:32] : mem_rdata[31:0];

  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    excp_d    = excp_q;
    advance   = 1'b0;
    req_int   = 1'b0;
    case (state_q)
      ST_REQ: begin
        if (misaligned) begin
          // A redirect this cycle replaces the PC, so only present the nop otherwise.
          if (!redir_valid) begin
            state_d   = ST_HOLD;
            inst_d    = NOP_INST;
            inst_pc_d = pc;
            excp_d    = 1'b1;
          end
        end else begin
          req_int = 1'b1;
          if (mem_gnt) begin
            state_d   = ST_WAIT;
            // Granted at the old address while redirecting: its response is stale.
            discard_d = redir_valid;
          end
        end
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          discard_d = 1'b0;
          if (discard_q || redir_valid) begin
            state_d = ST_REQ;
          end else begin
            state_d   = ST_HOLD;
            inst_d    = word_sel;
            inst_pc_d = pc;
            excp_d    = 1'b0;
          end
        end else if (redir_valid) begin
          discard_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (redir_valid) begin
          state_d = ST_REQ;
        end else if (inst_ready) begin
          state_d = ST_REQ;
          advance = 1'b1;
        end
      end
      default: state_d = ST_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_REQ;
      discard_q <= 1'b0;
      inst_q    <= 32'h0;
      inst_pc_q <= '0;
      excp_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      excp_q    <= excp_d;
    end
  end

  // Request is suppressed while reset is held so nothing is issued before the PC is valid.
  assign mem_req    = req_int & ~rst;
  assign mem_addr   = {pc[ADDR_W-1:3], 3'b000};
  assign inst_valid = (state_q == ST_HOLD);
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_excp  = excp_q;

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

  typedef struct packed {
    logic        excp;
    logic [31:0] inst;
    logic [63:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic        mem_gnt;
  logic [63:0] mem_addr;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_excp;
  logic        redir_valid;
  logic [63:0] redir_pc;

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  inst_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .mem_req     (mem_req),
    .mem_gnt     (mem_gnt),
    .mem_addr    (mem_addr),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_excp   (inst_excp),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc)
  );

  initial begin
    #500000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every decode handshake pops one expected word.
  task automatic mon();
    exp_t e;
    if (rst === 1'b0 && inst_valid === 1'b1 && inst_ready === 1'b1) begin
      total++;
      assert (exp_q.size() > 0) else begin
        bad++;
        $error("FAIL hs_unexpected obs inst=%h pc=%h exp=none", inst, inst_pc);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        assert ({inst_excp, inst, inst_pc} === e) else begin
          bad++;
          $error("FAIL hs_word obs=%h/%h/%h exp=%h/%h/%h",
                 inst_excp, inst, inst_pc, e.excp, e.inst, e.pc);
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic [63:0] a);
    int n = 0;
    while (mem_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("req_seen", {63'b0, mem_req}, 64'd1);
    chk("req_addr", mem_addr, a);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    chk("req_drop", {63'b0, mem_req}, 64'd0);
  endtask

  task automatic do_resp(input logic [63:0] d, input bit push, input logic [31:0] ei,
                         input logic [63:0] ep);
    exp_t e;
    mem_rvalid = 1'b1;
    mem_rdata  = d;
    if (push) begin
      e.excp = 1'b0;
      e.inst = ei;
      e.pc   = ep;
      exp_q.push_back(e);
    end
    step();
    mem_rvalid = 1'b0;
    mem_rdata  = 64'h0;
  endtask

  initial begin
    exp_t e;
    rst         = 1'b1;
    mem_gnt     = 1'b0;
    mem_rvalid  = 1'b0;
    mem_rdata   = 64'h0;
    inst_ready  = 1'b1;
    redir_valid = 1'b0;
    redir_pc    = 64'h0;
    step();
    step();
    chk("rst_req",   {63'b0, mem_req},    64'd0);
    chk("rst_valid", {63'b0, inst_valid}, 64'd0);
    chk("rst_inst",  {32'b0, inst},       64'd0);
    chk("rst_pc",    inst_pc,             64'd0);
    chk("rst_excp",  {63'b0, inst_excp},  64'd0);
    rst = 1'b0;
    #1;
    chk("first_req",  {63'b0, mem_req}, 64'd1);
    chk("first_addr", mem_addr, 64'h8000_0000);

    // Two words from one doubleword, ready held high.
    do_req(64'h8000_0000);
    do_resp(64'h0000_0073_0010_0113, 1'b1, 32'h0010_0113, 64'h8000_0000);
    chk("lat_valid", {63'b0, inst_valid}, 64'd1);
    step();
    do_req(64'h8000_0000);
    do_resp(64'h0000_0073_0010_0113, 1'b1, 32'h0000_0073, 64'h8000_0004);
    step();

    // Decode stall for 5 cycles.
    inst_ready = 1'b0;
    do_req(64'h8000_0008);
    do_resp(64'h1111_2222_3333_4444, 1'b1, 32'h3333_4444, 64'h8000_0008);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", {63'b0, inst_valid}, 64'd1);
      chk("stall_inst",  {32'b0, inst},       64'h3333_4444);
      chk("stall_pc",    inst_pc,             64'h8000_0008);
      chk("stall_noreq", {63'b0, mem_req},    64'd0);
      step();
    end
    inst_ready = 1'b1;
    step();

    // Redirect while waiting for data: in-flight word dropped.
    do_req(64'h8000_0008);
    redir_valid = 1'b1;
    redir_pc    = 64'h8000_0100;
    step();
    redir_valid = 1'b0;
    chk("wredir_noreq", {63'b0, mem_req}, 64'd0);
    do_resp(64'hDEAD_BEEF_DEAD_BEEF, 1'b0, 32'h0, 64'h0);
    chk("wredir_novalid", {63'b0, inst_valid}, 64'd0);
    do_req(64'h8000_0100);
    do_resp(64'hAAAA_BBBB_CCCC_DDDD, 1'b1, 32'hCCCC_DDDD, 64'h8000_0100);
    step();

    // Redirect coincident with the hold handshake: word taken once.
    do_req(64'h8000_0100);
    do_resp(64'hAAAA_BBBB_CCCC_DDDD, 1'b1, 32'hAAAA_BBBB, 64'h8000_0104);
    redir_valid = 1'b1;
    redir_pc    = 64'h8000_0200;
    step();
    redir_valid = 1'b0;
    do_req(64'h8000_0200);
    do_resp(64'h5555_6666_7777_8888, 1'b1, 32'h7777_8888, 64'h8000_0200);
    step();

    // Redirect coincident with read data: response dropped.
    do_req(64'h8000_0200);
    redir_valid = 1'b1;
    redir_pc    = 64'h8000_0300;
    do_resp(64'h1234_5678_9ABC_DEF0, 1'b0, 32'h0, 64'h0);
    redir_valid = 1'b0;
    chk("rvredir_novalid", {63'b0, inst_valid}, 64'd0);
    chk("rvredir_addr", mem_addr, 64'h8000_0300);
    do_req(64'h8000_0300);
    do_resp(64'h1234_5678_9ABC_DEF0, 1'b1, 32'h9ABC_DEF0, 64'h8000_0300);
    step();

    // Grant withheld: request stable.
    for (int i = 0; i < 4; i++) begin
      chk("nognt_req",  {63'b0, mem_req}, 64'd1);
      chk("nognt_addr", mem_addr, 64'h8000_0300);
      step();
    end
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;

    // Reset while waiting for data.
    rst = 1'b1;
    step();
    chk("mrst_valid", {63'b0, inst_valid}, 64'd0);
    chk("mrst_pc",    inst_pc,             64'd0);
    chk("mrst_req",   {63'b0, mem_req},    64'd0);
    rst = 1'b0;
    #1;
    chk("mrst_addr", mem_addr, 64'h8000_0000);
    chk("mrst_req1", {63'b0, mem_req}, 64'd1);

    // PC wrap at the top of the address space.
    redir_valid = 1'b1;
    redir_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    redir_valid = 1'b0;
    do_req(64'hFFFF_FFFF_FFFF_FFF8);
    do_resp(64'hCAFE_F00D_0BAD_BEEF, 1'b1, 32'hCAFE_F00D, 64'hFFFF_FFFF_FFFF_FFFC);
    step();
    do_req(64'h0);
    do_resp(64'hCAFE_F00D_0BAD_BEEF, 1'b1, 32'h0BAD_BEEF, 64'h0);
    step();

    // Misaligned redirect target.
    redir_valid = 1'b1;
    redir_pc    = 64'h8000_0002;
    step();
    redir_valid = 1'b0;
`ifdef INST_FETCH_ALIGN_CHK_EN
    chk("mis_noreq", {63'b0, mem_req}, 64'd0);
    inst_ready = 1'b0;
    step();
    chk("mis_noreq2", {63'b0, mem_req},    64'd0);
    chk("mis_valid",  {63'b0, inst_valid}, 64'd1);
    chk("mis_excp",   {63'b0, inst_excp},  64'd1);
    chk("mis_inst",   {32'b0, inst},       64'h0000_0013);
    chk("mis_pc",     inst_pc,             64'h8000_0002);
    e.excp = 1'b1;
    e.inst = 32'h0000_0013;
    e.pc   = 64'h8000_0002;
    exp_q.push_back(e);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
`else
    chk("mis_addr", mem_addr, 64'h8000_0000);
    do_req(64'h8000_0000);
    do_resp(64'h0000_0073_0010_0113, 1'b1, 32'h0010_0113, 64'h8000_0002);
    chk("mis_excp0", {63'b0, inst_excp}, 64'd0);
    step();
`endif

    step();
    step();
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
